// File: rtl/lcd_mode_arbiter_if.sv
// lcd_mode_arbiter_if
// UART mode-byte handshake between the serial receiver (master) and the
// LCD mode arbiter (slave).
//
// Handshake: a byte transfers on a rising clk edge where uart_valid and
// uart_ready are both high. The master holds uart_mode stable while
// uart_valid is high. uart_ready depends only on arbiter state, never on
// uart_valid.
interface lcd_mode_arbiter_if;
  logic       uart_valid;
  logic [7:0] uart_mode;
  logic       uart_ready;

  modport master (
    output uart_valid,
    output uart_mode,
    input  uart_ready
  );

  modport slave (
    input  uart_valid,
    input  uart_mode,
    output uart_ready
  );
endinterface

// File: rtl/lcd_mode_arbiter.sv
// lcd_mode_arbiter
// Shares the LCD1602 driver's single mode byte between the Nios PIO mode
// export (level, change-detected) and a UART-received mode byte
// (valid/ready). One requester is granted at a time. Its byte is driven on
// mode_out with a one-cycle mode_strobe, and it is then held for
// HOLD_CYCLES clocks before the next grant.
//
// Optional build macro: LCD_ARB_FIXED_PRIO_EN
//   defined   -> when both requesters are pending, UART always wins the tie
//                (the CPU can be starved).
//   undefined -> round-robin tie-break against the last granted owner.
//
// state_dbg exposes the FSM state: 0 = IDLE, 1 = LOAD, 2 = HOLD.
module lcd_mode_arbiter #(
  parameter int         HOLD_CYCLES  = 50000000,
  parameter int         CNT_W        = 26,
  parameter logic [7:0] DEFAULT_MODE = 8'h00
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           cpu_mode,
  lcd_mode_arbiter_if.slave    uart,
  output logic [7:0]           mode_out,
  output logic                 mode_strobe,
  output logic                 busy,
  output logic                 owner,
  output logic [1:0]           state_dbg
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // FSM and timing
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;          // 0 = CPU, 1 = UART
  logic             last_owner_q, last_owner_d;

  // CPU request slot
  logic [7:0]       cpu_prev_q, cpu_prev_d;
  logic             cpu_pend_q, cpu_pend_d;
  logic [7:0]       cpu_val_q, cpu_val_d;

  // UART request slot
  logic             uart_pend_q, uart_pend_d;
  logic [7:0]       uart_val_q, uart_val_d;

  // Registered outputs
  logic [7:0]       mode_out_q, mode_out_d;
  logic             mode_strobe_q, mode_strobe_d;
  logic             busy_q, busy_d;
  logic             owner_q, owner_d;

  // Request-side helpers
  logic             cpu_change;
  logic             uart_accept;
  logic             pick_uart;
  logic             clear_cpu;
  logic             clear_uart;

  assign cpu_change  = (cpu_mode != cpu_prev_q);
  assign uart_accept = uart.uart_valid && !uart_pend_q;

  // UART slot is a single byte; ready simply means the slot is empty
  assign uart.uart_ready = !uart_pend_q;

  assign mode_out    = mode_out_q;
  assign mode_strobe = mode_strobe_q;
  assign busy        = busy_q;
  assign owner       = owner_q;
  assign state_dbg   = state_q;

  // Tie-break: decides whether UART is granted when IDLE sees a request
`ifdef LCD_ARB_FIXED_PRIO_EN
  assign pick_uart = uart_pend_q;
`else
  // Both pending: grant whoever did not own the last grant
  assign pick_uart = uart_pend_q && (!cpu_pend_q || !last_owner_q);
`endif

  // Next-state logic for the FSM, request slots and outputs
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sel_d         = sel_q;
    last_owner_d  = last_owner_q;
    cpu_prev_d    = cpu_prev_q;
    cpu_pend_d    = cpu_pend_q;
    cpu_val_d     = cpu_val_q;
    uart_pend_d   = uart_pend_q;
    uart_val_d    = uart_val_q;
    mode_out_d    = mode_out_q;
    mode_strobe_d = 1'b0;
    owner_d       = owner_q;
    clear_cpu     = 1'b0;
    clear_uart    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_pend_q || uart_pend_q) begin
          sel_d   = pick_uart;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // The winner's slot value is sampled here, so a CPU change that
        // landed during LOAD is shown by this grant only if it arrived
        // before this edge; later ones stay pending for the next grant.
        mode_out_d    = sel_q ? uart_val_q : cpu_val_q;
        mode_strobe_d = 1'b1;
        owner_d       = sel_q;
        last_owner_d  = sel_q;
        clear_uart    = sel_q;
        clear_cpu     = !sel_q;
        cnt_d         = CNT_LOAD;
        state_d       = ST_HOLD;
      end

      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // CPU slot: a fresh change overrides a same-edge grant clear
    if (clear_cpu) begin
      cpu_pend_d = 1'b0;
    end
    if (cpu_change) begin
      cpu_pend_d = 1'b1;
      cpu_val_d  = cpu_mode;
      cpu_prev_d = cpu_mode;
    end

    // UART slot: accept and clear are mutually exclusive since ready is low while full
    if (clear_uart) begin
      uart_pend_d = 1'b0;
    end
    if (uart_accept) begin
      uart_pend_d = 1'b1;
      uart_val_d  = uart.uart_mode;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sel_q         <= 1'b0;
      last_owner_q  <= 1'b1;
      cpu_prev_q    <= DEFAULT_MODE;
      cpu_pend_q    <= 1'b0;
      cpu_val_q     <= DEFAULT_MODE;
      uart_pend_q   <= 1'b0;
      uart_val_q    <= 8'h00;
      mode_out_q    <= DEFAULT_MODE;
      mode_strobe_q <= 1'b0;
      busy_q        <= 1'b0;
      owner_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      last_owner_q  <= last_owner_d;
      cpu_prev_q    <= cpu_prev_d;
      cpu_pend_q    <= cpu_pend_d;
      cpu_val_q     <= cpu_val_d;
      uart_pend_q   <= uart_pend_d;
      uart_val_q    <= uart_val_d;
      mode_out_q    <= mode_out_d;
      mode_strobe_q <= mode_strobe_d;
      busy_q        <= busy_d;
      owner_q       <= owner_d;
    end
  end

endmodule

// File: tb/tb_lcd_mode_arbiter.sv
// tb_lcd_mode_arbiter
// Directed bench for lcd_mode_arbiter with HOLD_CYCLES = 4.
// Inputs change right after a falling edge; outputs are sampled on falling
// edges, half a period away from the active rising edge.
module tb_lcd_mode_arbiter;

  localparam int HOLD = 4;

  logic       clk;
  logic       reset_n;
  logic [7:0] cpu_mode;
  logic [7:0] mode_out;
  logic       mode_strobe;
  logic       busy;
  logic       owner;
  logic [1:0] state_dbg;

  lcd_mode_arbiter_if u_if ();

  lcd_mode_arbiter #(
    .HOLD_CYCLES (HOLD),
    .CNT_W       (3),
    .DEFAULT_MODE(8'h00)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_mode   (cpu_mode),
    .uart       (u_if),
    .mode_out   (mode_out),
    .mode_strobe(mode_strobe),
    .busy       (busy),
    .owner      (owner),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q[$];   // {owner, mode} of each expected grant, in order

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_grant(input logic own, input logic [7:0] mode);
    exp_q.push_back({own, mode});
  endtask

  task automatic check_grant(input string tag);
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s observed=%0h expected=<empty queue>", tag, {owner, mode_out});
    end else begin
      e = exp_q.pop_front();
      check(tag, {23'd0, owner, mode_out}, {23'd0, e});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [7:0] cpu);
    reset_n        = 1'b0;
    cpu_mode       = cpu;
    u_if.uart_valid = 1'b0;
    u_if.uart_mode  = 8'h00;
    repeat (3) tick();
    reset_n = 1'b1;
  endtask

  // Waits up to budget falling edges for a strobe; n = edges waited
  task automatic wait_strobe(input string tag, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (mode_strobe !== 1'b1 && n < budget);
    check(tag, {31'd0, mode_strobe}, 32'd1);
  endtask

  task automatic count_strobes(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (mode_strobe === 1'b1) cnt++;
    end
  endtask

  // ---------------- directed sequence ----------------
  int n;
  int nstb;

  initial begin
    reset_n         = 1'b0;
    cpu_mode        = 8'h00;
    u_if.uart_valid = 1'b0;
    u_if.uart_mode  = 8'h00;

    // 1: reset values, then quiet with cpu_mode held at default
    do_reset(8'h00);
    check("rst_mode", {24'd0, mode_out}, 32'h00);
    check("rst_strobe", {31'd0, mode_strobe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, u_if.uart_ready}, 32'd1);
    check("rst_owner", {31'd0, owner}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    count_strobes(20, nstb);
    check("quiet_no_strobe", nstb, 32'd0);

    // 2: CPU change 00->03, latency and busy window
    cpu_mode = 8'h03;
    tick();
    check("cpu_busy_e0", {31'd0, busy}, 32'd0);
    tick();
    check("cpu_busy_e1", {31'd0, busy}, 32'd1);
    check("cpu_strobe_e1", {31'd0, mode_strobe}, 32'd0);
    expect_grant(1'b0, 8'h03);
    tick();
    check("cpu_strobe_e2", {31'd0, mode_strobe}, 32'd1);
    check_grant("cpu_grant_03");
    tick();
    check("cpu_strobe_1cyc", {31'd0, mode_strobe}, 32'd0);
    repeat (2) tick();
    check("cpu_busy_last", {31'd0, busy}, 32'd1);
    tick();
    check("cpu_busy_drop", {31'd0, busy}, 32'd0);

    // 3: simultaneous CPU 05 and UART 81 from reset: CPU first, UART 6 later
    do_reset(8'h00);
    expect_grant(1'b0, 8'h05);
    expect_grant(1'b1, 8'h81);
    cpu_mode        = 8'h05;
    u_if.uart_valid = 1'b1;
    u_if.uart_mode  = 8'h81;
    tick();
    u_if.uart_valid = 1'b0;
    check("tie_ready_low", {31'd0, u_if.uart_ready}, 32'd0);
    wait_strobe("tie_strobe1", 10, n);
    check("tie_lat1", n, 32'd2);
    check_grant("tie_grant_05");
    repeat (HOLD + 1) tick();
    check("tie_ready_hold", {31'd0, u_if.uart_ready}, 32'd0);
    check("tie_no_early", {31'd0, mode_strobe}, 32'd0);
    tick();
    check("tie_strobe2", {31'd0, mode_strobe}, 32'd1);
    check_grant("tie_grant_81");
    check("tie_ready_back", {31'd0, u_if.uart_ready}, 32'd1);

    // 4: coalescing of CPU changes during HOLD
    do_reset(8'h00);
    expect_grant(1'b0, 8'h05);
    cpu_mode = 8'h05;
    wait_strobe("coal_strobe1", 10, n);
    check("coal_lat1", n, 32'd3);
    check_grant("coal_grant_05");
    tick(); cpu_mode = 8'h01;
    tick(); cpu_mode = 8'h02;
    tick(); cpu_mode = 8'h07;
    expect_grant(1'b0, 8'h07);
    wait_strobe("coal_strobe2", 12, n);
    check("coal_spacing", n, 32'd3);
    check_grant("coal_grant_07");
    count_strobes(15, nstb);
    check("coal_single", nstb, 32'd0);

    // 5: asynchronous reset mid-HOLD with a UART byte pending
    do_reset(8'h00);
    expect_grant(1'b0, 8'h0A);
    cpu_mode        = 8'h0A;
    u_if.uart_valid = 1'b1;
    u_if.uart_mode  = 8'h55;
    tick();
    u_if.uart_valid = 1'b0;
    wait_strobe("ares_strobe", 10, n);
    check_grant("ares_grant_0a");
    repeat (2) tick();
    check("ares_busy_pre", {31'd0, busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("ares_mode", {24'd0, mode_out}, 32'h00);
    check("ares_busy", {31'd0, busy}, 32'd0);
    check("ares_owner", {31'd0, owner}, 32'd0);
    check("ares_ready", {31'd0, u_if.uart_ready}, 32'd1);
    check("ares_strobe0", {31'd0, mode_strobe}, 32'd0);
    check("ares_state", {30'd0, state_dbg}, 32'd0);
    cpu_mode = 8'h00;
    repeat (2) tick();
    reset_n = 1'b1;
    count_strobes(20, nstb);
    check("ares_discard", nstb, 32'd0);

    // 6: both pending from reset (cpu 09, uart 42); order depends on build
    reset_n         = 1'b0;
    cpu_mode        = 8'h09;
    u_if.uart_valid = 1'b1;
    u_if.uart_mode  = 8'h42;
    repeat (2) tick();
`ifdef LCD_ARB_FIXED_PRIO_EN
    expect_grant(1'b1, 8'h42);
    expect_grant(1'b0, 8'h09);
`else
    expect_grant(1'b0, 8'h09);
    expect_grant(1'b1, 8'h42);
`endif
    reset_n = 1'b1;
    tick();
    u_if.uart_valid = 1'b0;
    wait_strobe("prio_strobe1", 10, n);
    check("prio_lat1", n, 32'd2);
    check_grant("prio_grant1");
    wait_strobe("prio_strobe2", 12, n);
    check("prio_spacing", n, HOLD + 2);
    check_grant("prio_grant2");
    check("prio_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lcd_mode_arbiter.md
Name: lcd_mode_arbiter

Overview:
- Shares the single 8-bit LCD1602 mode input (modooperacao) between two requesters:
  - the Nios PIO mode export, a level-type byte;
  - a UART-received mode byte, using a valid/ready handshake.
- Selects one requester at a time, drives the LCD driver's mode byte, then holds it for a minimum display time before granting again.
- Sits between the processor system / serial receiver and the LCD1602 driver in the top level.

Parameters:
- HOLD_CYCLES, 50000000, minimum clk cycles a granted mode stays on mode_out (legal range ≥1).
- CNT_W, 26, hold counter width; must satisfy 2^CNT_W > HOLD_CYCLES.
- DEFAULT_MODE, 8'h00, mode_out and cpu_prev value at reset.

Ports:
- clk  input  1  system clock (50 MHz).
- reset_n  input  1  asynchronous active-low reset.
- cpu_mode  input  8  mode byte from processor PIO, level, same clock domain.
- uart_valid  input  1  UART mode byte valid.
- uart_mode  input  8  UART mode byte.
- uart_ready  output  1  arbiter can accept a UART byte.
- mode_out  output  8  to LCD1602 modooperacao.
- mode_strobe  output  1  one-cycle pulse when mode_out updates.
- busy  output  1  state is LOAD or HOLD.
- owner  output  1  source of current mode_out (0 = CPU, 1 = UART).

Behaviour:

CPU request detection:
- Register cpu_prev; a change exists when cpu_mode != cpu_prev.
- On a change edge: cpu_pend <= 1, cpu_val <= cpu_mode, cpu_prev <= cpu_mode.
- Changes arriving while cpu_pend is set overwrite cpu_val. Coalescing: only the latest value is ever displayed.
- If a change and a grant-clear of cpu_pend occur on the same edge, set wins: pend stays 1 and the new value is stored.

UART path:
- uart_ready = !uart_pend (combinational).
- Accept on valid && ready: uart_pend <= 1, uart_val <= uart_mode.
- Accept and clear cannot coincide, because ready is low while the slot is full.

State machine (IDLE, LOAD, HOLD):
- IDLE:
  - Any pend set → LOAD; latch the winner into sel.
  - Round-robin: when both are pending, grant the requester that is not last_owner.
  - last_owner resets to 1, so the CPU wins the first tie.
- LOAD (1 cycle), at the exiting edge:
  - mode_out <= winner value; mode_strobe <= 1 for exactly one cycle; owner <= sel; last_owner <= sel.
  - Clear the winner's pend; cnt <= HOLD_CYCLES-1; → HOLD.
- HOLD:
  - cnt decrements each cycle.
  - At cnt == 0 → IDLE. HOLD therefore lasts HOLD_CYCLES cycles.

Timing:
- Latency: pend set at edge E0 → LOAD at E1 → mode_out/strobe valid after E2.
- Back-to-back pending requests produce strobes exactly HOLD_CYCLES+2 cycles apart. This is also the minimum spacing.
- A granted value equal to the current mode_out still strobes and runs the full HOLD.
- busy = 1 in LOAD and HOLD. busy and mode_strobe are registered.

Reset (asynchronous, any state including mid-HOLD):
- mode_out = DEFAULT_MODE, mode_strobe = 0, busy = 0, owner = 0, uart_ready = 1.
- cpu_prev = DEFAULT_MODE; pends cleared; cnt = 0; state IDLE; last_owner = 1.
- A cpu_mode ≠ DEFAULT_MODE present at reset release raises a CPU request on the first edge.

Optional Feature:
- Macro LCD_ARB_FIXED_PRIO_EN.
- Defined: the IDLE tie-break is fixed priority, UART over CPU. last_owner is unused, and the CPU can be starved while UART bytes keep arriving.
- Undefined: round-robin as described under Behaviour.
- All other behaviour is identical in both builds.

Test Plan (HOLD_CYCLES = 4 unless noted):
- Reset with cpu_mode = 00 held → mode_out = 00, strobe 0, busy 0, uart_ready 1, owner 0; no strobe for 20 cycles.
- cpu_mode 00→03 at edge E0 → strobe pulse with mode_out = 03, owner 0, after E2. busy high for 5 cycles, low 1 cycle later.
- Edge E0: cpu_mode→05 and uart_valid with 0x81 together → strobe 05 (owner 0) first. Strobe 0x81 (owner 1) follows 6 cycles later. uart_ready is low from accept until the 0x81 LOAD edge.
- During HOLD of 05, cpu_mode 01→02→07 → next strobe shows 07 only; exactly one CPU grant.
- Assert reset_n = 0 mid-HOLD with a UART byte pending → outputs return to reset values immediately, with no clk edge needed. After release no strobe occurs: the pending byte is discarded.
- With LCD_ARB_FIXED_PRIO_EN and both pending from reset (cpu 09, uart 0x42) → 0x42 is granted first, then 09.
